fpu_requester: RTL

Initiator-side sequencer for the FPU controller stb/ack protocol. It accepts one floating-point request from the core pipeline (op, two operands) and drives the operand strobes. It then collects the result over the out_stb/out_ack handshake and returns a single-cycle response. It sits between the execute stage and the FPU controller, and is the only agent that drives the controller's op, in1, in2, in*_stb and out_ack.

---
 rtl/fpu_requester.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fpu_requester.sv
// fpu_requester: initiator-side sequencer for the FPU controller stb/ack
// protocol. Accepts one request (op, a, b) from the core, drives the operand
// strobes, collects the result over out_stb/out_ack and returns a one-cycle
// response.
//
// Optional feature: define FPU_REQ_TIMEOUT_EN to add a watchdog that aborts
// SEND/WAIT after TIMEOUT_CYCLES clocks with resp_err=1. Without it the
// sequencer waits on the FPU indefinitely.
//
// Handshake rules: a request is accepted at a rising edge where
// req_valid && req_ready; an operand transfers at an edge where
// fpu_inN_stb && fpu_inN_ack; the result transfers at an edge where
// fpu_out_stb && fpu_out_ack. Strobes never drop before their transfer
// (except on watchdog abort or reset).
module fpu_requester #(
    parameter logic [3:0] LAST_OP        = 4'd7,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [3:0]  fpu_op,
    output logic [31:0] fpu_in1,
    output logic [31:0] fpu_in2,
    output logic        fpu_in1_stb,
    output logic        fpu_in2_stb,
    input  logic        fpu_in1_ack,
    input  logic        fpu_in2_ack,
    input  logic [31:0] fpu_out,
    input  logic        fpu_out_stb,
    output logic        fpu_out_ack,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // A watchdog limit of zero would time out before any cycle is counted.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fpu_requester: TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state_q;
    logic [3:0]  op_q;
    logic [31:0] in1_q;
    logic [31:0] in2_q;
    logic        in1_stb_q;
    logic        in2_stb_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_data_q;

    // Strobe values for the next cycle while in SEND: a strobe drops once
    // its operand has been taken and stays low.
    logic        in1_stb_d;
    logic        in2_stb_d;

`ifdef FPU_REQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          tmo;

    // Watchdog fires on the edge that completes the TIMEOUT_CYCLES-th
    // counted cycle in SEND/WAIT.
    assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif

    // Per-operand transfer tracking; a transfer clears its own strobe.
    always_comb begin
        in1_stb_d = in1_stb_q && !fpu_in1_ack;
        in2_stb_d = in2_stb_q && !fpu_in2_ack;
    end

    // Sequencer FSM with registered FPU-side and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            in1_q        <= '0;
            in2_q        <= '0;
            in1_stb_q    <= 1'b0;
            in2_stb_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
`ifdef FPU_REQ_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q  <= req_op;
                        in1_q <= req_a;
                        in2_q <= req_b;
                        if (req_op > LAST_OP) begin
                            // Illegal op completes locally; the FPU never sees a strobe.
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_data_q  <= '0;
                        end else begin
                            state_q   <= S_SEND;
                            in1_stb_q <= 1'b1;
                            in2_stb_q <= 1'b1;
`ifdef FPU_REQ_TIMEOUT_EN
                            cnt_q     <= '0;
`endif
                        end
                    end
                end
                S_SEND: begin
                    in1_stb_q <= in1_stb_d;
                    in2_stb_q <= in2_stb_d;
                    if (!in1_stb_d && !in2_stb_d) begin
                        state_q <= S_WAIT;
                    end
`ifdef FPU_REQ_TIMEOUT_EN
                    else if (tmo) begin
                        in1_stb_q    <= 1'b0;
                        in2_stb_q    <= 1'b0;
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_data_q  <= '0;
                    end
                    cnt_q <= cnt_q + 1'b1;
`endif
                end
                S_WAIT: begin
                    if (fpu_out_stb) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_data_q  <= fpu_out;
                    end
`ifdef FPU_REQ_TIMEOUT_EN
                    else if (tmo) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_data_q  <= '0;
                    end
                    cnt_q <= cnt_q + 1'b1;
`endif
                end
                S_RESP: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // State-decoded outputs; fpu_out_ack has no path from fpu_out_stb.
    assign req_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign fpu_out_ack = (state_q == S_WAIT);
    assign dbg_state_o = state_q;

    assign fpu_op      = op_q;
    assign fpu_in1     = in1_q;
    assign fpu_in2     = in2_q;
    assign fpu_in1_stb = in1_stb_q;
    assign fpu_in2_stb = in2_stb_q;
    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;
    assign resp_data   = resp_data_q;

endmodule
